seven_seg_scan: RTL and testbench
=================================

SEVEN_SEG_SCAN -- requirements
Module: seven_seg_scan

Interface
REQ-001 The block SHALL provide these parameters (name, default, meaning):
- DIGITS, 4: number of multiplexed digits, legal range 1..8.
- REFRESH_DIV, 1000: clock cycles per digit slot, minimum 2.
- DEAD_CYCLES, 2: blanking cycles at the start of each slot, less than REFRESH_DIV.
- SEG_ACTIVE_LOW, 0: 1 inverts o_seg_vals.
- DIG_ACTIVE_LOW, 0: 1 inverts o_digit_sel.

REQ-002 The block SHALL provide these ports (name, direction, width, meaning):
- i_clk, in, 1: single clock, rising edge.
- i_rst_n, in, 1: reset, asynchronous, active-low.
- i_en, in, 1: scan enable.
- i_load, in, 1: single-cycle pulse; capture i_val, i_dp and i_blank into the pending register.
- i_val, in, 4*DIGITS: hex nibble per digit; digit k uses bits [4k+3:4k]; digit 0 is least significant.
- i_dp, in, DIGITS: decimal point per digit.
- i_blank, in, DIGITS: force digit blank.
- i_lz_en, in, 1: leading-zero suppression enable.
- o_seg_vals, out, 8: segment drive; bit 7 is the decimal point.
- o_digit_sel, out, DIGITS: one-hot digit enable.
- o_pending, out, 1: pending value not yet displayed.
- o_frame, out, 1: one-cycle pulse at each frame boundary.

Function
REQ-003 Nibble decode SHALL be, for nibbles 0..F: 5f, 06, 3b, 2f, 66, 6d, 7d, 07, 7f, 6f, 77, 7c, 59, 3e, 79, 71 (hex, bits 6:0, active-high); bit 7 = i_dp of that digit.
REQ-004 Slot counter SHALL count 0..REFRESH_DIV-1 while i_en=1; at terminal count it wraps to 0 and the digit index advances, wrapping DIGITS-1 -> 0.
REQ-005 On the transition of the digit index to 0 (frame boundary), o_frame SHALL pulse for 1 cycle.
REQ-006 The pending register SHALL be committed to the display register at the frame boundary, and o_pending SHALL clear on that commit.
REQ-007 i_load SHALL set o_pending the following cycle; a second i_load before commit SHALL overwrite the pending value (last write wins).
REQ-008 If i_load coincides with the commit cycle, the new i_val/i_dp/i_blank SHALL be committed directly and o_pending SHALL remain 0.
REQ-009 During slot counts 0..DEAD_CYCLES-1 and outside those counts when the digit is blanked, o_seg_vals and o_digit_sel SHALL be at their inactive levels.
REQ-010 Outside the dead counts, o_digit_sel SHALL be one-hot on the current index and o_seg_vals SHALL be the decode of that display digit.
REQ-011 Outputs SHALL be registered, with latency of exactly 1 cycle from the counter/index state.
REQ-012 A digit SHALL be blanked when i_blank[k]=1 in the display register, or when i_lz_en=1, k>0, and all display nibbles k..DIGITS-1 are 0.
REQ-013 Digit 0 SHALL never be suppressed by the leading-zero rule.
REQ-014 A blanked digit SHALL also suppress its dp, and its digit select SHALL be inactive.
REQ-015 Inactive level SHALL be all 0, or all 1 when the corresponding *_ACTIVE_LOW=1; polarity SHALL be applied as the last stage.
REQ-016 While i_en=0, the slot counter and digit index SHALL be held at 0, outputs SHALL be inactive, o_frame SHALL be 0, and i_load SHALL still be accepted.
REQ-017 Re-asserting i_en SHALL start at digit 0, count 0, and SHALL commit any pending value on the first cycle.

Reset
REQ-018 While i_rst_n=0 (asynchronous, effective mid-slot), counter, index, display and pending registers SHALL be 0, o_pending=0, o_frame=0, and o_seg_vals/o_digit_sel SHALL be inactive.
REQ-019 After release, the first visible digit SHALL be digit 0 showing 0x5f (or 0 per blanking rules) at count DEAD_CYCLES+1.

Verification (DIGITS=4, REFRESH_DIV=8, DEAD_CYCLES=2, i_en=1)
REQ-020 Load 0x12AF, wait for o_frame -> digit0 slot shows seg 0x71 with sel 0001, then digits 1..3 show 0x77, 0x3b, 0x06; o_pending falls at o_frame.
REQ-021 i_lz_en=1, load 0x0005 -> digits 3..1 inactive, digit0 shows 0x6d; load 0x0000 -> digit0 shows 0x5f.
REQ-022 Load 0x1111 then 0x2222 within one frame -> only 0x3b is displayed after commit.
REQ-023 SEG_ACTIVE_LOW=1, DIG_ACTIVE_LOW=1, value 1 on digit0 -> seg 0xF9, sel 1110; dead cycles show 0xFF/1111.
REQ-024 i_dp=0100 with value 0x8888 -> digit2 shows 0xFF, other digits show 0x7F.
REQ-025 Assert i_rst_n=0 mid-slot of digit2 -> outputs inactive within the same cycle; after release, digit0 shows 0x5f.

Source files
------------

// File: rtl/seven_seg_scan_if.sv
// Input/output bundle of the multiplexed seven-segment scanner.
// master drives the value/load/enable side, slave is the scanner itself.
interface seven_seg_scan_if #(
  parameter int DIGITS = 4
);
  logic                  i_en;
  logic                  i_load;
  logic [4*DIGITS-1:0]   i_val;
  logic [DIGITS-1:0]     i_dp;
  logic [DIGITS-1:0]     i_blank;
  logic                  i_lz_en;
  logic [7:0]            o_seg_vals;
  logic [DIGITS-1:0]     o_digit_sel;
  logic                  o_pending;
  logic                  o_frame;

  modport master (
    output i_en, i_load, i_val, i_dp, i_blank, i_lz_en,
    input  o_seg_vals, o_digit_sel, o_pending, o_frame
  );

  modport slave (
    input  i_en, i_load, i_val, i_dp, i_blank, i_lz_en,
    output o_seg_vals, o_digit_sel, o_pending, o_frame
  );
endinterface

// File: rtl/seven_seg_scan.sv
// Time-multiplexed hex display scanner with double-buffered value, dead-time and leading-zero blanking.
// Outputs registered, 1 cycle after counter/index state; no backpressure, i_load is always accepted.
module seven_seg_scan #(
  parameter int DIGITS         = 4,
  parameter int REFRESH_DIV    = 1000,
  parameter int DEAD_CYCLES    = 2,
  parameter bit SEG_ACTIVE_LOW = 1'b0,
  parameter bit DIG_ACTIVE_LOW = 1'b0
) (
  input logic            i_clk,
  input logic            i_rst_n,
  seven_seg_scan_if.slave bus
);
  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  function automatic logic [6:0] decode(input logic [3:0] nib);
    case (nib)
      4'h0: decode = 7'h5f;
      4'h1: decode = 7'h06;
      4'h2: decode = 7'h3b;
      4'h3: decode = 7'h2f;
      4'h4: decode = 7'h66;
      4'h5: decode = 7'h6d;
      4'h6: decode = 7'h7d;
      4'h7: decode = 7'h07;
      4'h8: decode = 7'h7f;
      4'h9: decode = 7'h6f;
      4'ha: decode = 7'h77;
      4'hb: decode = 7'h7c;
      4'hc: decode = 7'h59;
      4'hd: decode = 7'h3e;
      4'he: decode = 7'h79;
      default: decode = 7'h71;
    endcase
  endfunction

  logic [CW-1:0]       cnt;
  logic [IW-1:0]       idx;
  logic                en_q;
  logic [4*DIGITS-1:0] disp_val, pend_val;
  logic [DIGITS-1:0]   disp_dp, pend_dp, disp_blank, pend_blank;
  logic                pend_flag;
  logic [7:0]          seg_q;
  logic [DIGITS-1:0]   sel_q;
  logic                frame_q;

  logic                tc, last, frame_evt, commit;
  logic                hi_zero;
  logic [DIGITS-1:0]   blank_vec, sel_hit, sel_raw;
  logic [3:0]          nib;
  logic                dp_bit, blk, live;
  logic [7:0]          seg_raw;

  assign tc        = (cnt == CW'(REFRESH_DIV - 1));
  assign last      = (idx == IW'(DIGITS - 1));
  assign frame_evt = bus.i_en && tc && last;
  // Re-enabling counts as a commit point so a value loaded while idle shows immediately.
  assign commit    = bus.i_en && ((tc && last) || !en_q);

  always_comb begin
    hi_zero   = 1'b1;
    blank_vec = '0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      hi_zero      = hi_zero && (disp_val[4*k +: 4] == 4'h0);
      blank_vec[k] = disp_blank[k] || (bus.i_lz_en && (k > 0) && hi_zero);
    end
  end

  always_comb begin
    nib     = 4'h0;
    dp_bit  = 1'b0;
    blk     = 1'b0;
    sel_hit = '0;
    for (int k = 0; k < DIGITS; k++) begin
      if (idx == IW'(k)) begin
        nib        = disp_val[4*k +: 4];
        dp_bit     = disp_dp[k];
        blk        = blank_vec[k];
        sel_hit[k] = 1'b1;
      end
    end
    live    = bus.i_en && (int'(cnt) >= DEAD_CYCLES) && !blk;
    seg_raw = live ? {dp_bit, decode(nib)} : 8'h00;
    sel_raw = live ? sel_hit : '0;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt  <= '0;
      idx  <= '0;
      en_q <= 1'b0;
    end else begin
      en_q <= bus.i_en;
      if (!bus.i_en) begin
        cnt <= '0;
        idx <= '0;
      end else if (tc) begin
        cnt <= '0;
        idx <= last ? '0 : idx + IW'(1);
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  // Pending copy tracks every load so a later plain commit never replays stale data.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pend_val   <= '0;
      pend_dp    <= '0;
      pend_blank <= '0;
      pend_flag  <= 1'b0;
      disp_val   <= '0;
      disp_dp    <= '0;
      disp_blank <= '0;
    end else begin
      if (bus.i_load) begin
        pend_val   <= bus.i_val;
        pend_dp    <= bus.i_dp;
        pend_blank <= bus.i_blank;
      end
      if (commit) begin
        disp_val   <= bus.i_load ? bus.i_val   : pend_val;
        disp_dp    <= bus.i_load ? bus.i_dp    : pend_dp;
        disp_blank <= bus.i_load ? bus.i_blank : pend_blank;
        pend_flag  <= 1'b0;
      end else if (bus.i_load) begin
        pend_flag  <= 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      seg_q   <= {8{SEG_ACTIVE_LOW}};
      sel_q   <= {DIGITS{DIG_ACTIVE_LOW}};
      frame_q <= 1'b0;
    end else begin
      seg_q   <= seg_raw ^ {8{SEG_ACTIVE_LOW}};
      sel_q   <= sel_raw ^ {DIGITS{DIG_ACTIVE_LOW}};
      frame_q <= frame_evt;
    end
  end

  assign bus.o_seg_vals  = seg_q;
  assign bus.o_digit_sel = sel_q;
  assign bus.o_pending   = pend_flag;
  assign bus.o_frame     = frame_q;
endmodule

// File: tb/tb_seven_seg_scan.sv
// Directed bench: active-high scanner (a) and active-low twin (b) driven by identical inputs.
// Position pos counts negedges since the last frame boundary (state count 0 of digit 0).
module tb_seven_seg_scan;
  logic i_clk = 1'b0;
  logic i_rst_n;
  int   checks = 0;
  int   errors = 0;
  int   pos = 0;

  always #5 i_clk = ~i_clk;

  seven_seg_scan_if #(.DIGITS(4)) bus_a ();
  seven_seg_scan_if #(.DIGITS(4)) bus_b ();

  assign bus_b.i_en    = bus_a.i_en;
  assign bus_b.i_load  = bus_a.i_load;
  assign bus_b.i_val   = bus_a.i_val;
  assign bus_b.i_dp    = bus_a.i_dp;
  assign bus_b.i_blank = bus_a.i_blank;
  assign bus_b.i_lz_en = bus_a.i_lz_en;

  seven_seg_scan #(.DIGITS(4), .REFRESH_DIV(8), .DEAD_CYCLES(2),
                   .SEG_ACTIVE_LOW(1'b0), .DIG_ACTIVE_LOW(1'b0))
    dut_a (.i_clk(i_clk), .i_rst_n(i_rst_n), .bus(bus_a));

  seven_seg_scan #(.DIGITS(4), .REFRESH_DIV(8), .DEAD_CYCLES(2),
                   .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b1))
    dut_b (.i_clk(i_clk), .i_rst_n(i_rst_n), .bus(bus_b));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge i_clk);
    pos++;
  endtask

  task automatic goto(input int p);
    while (pos < p) step();
  endtask

  task automatic wait_frame();
    int n = 0;
    do begin
      step();
      n++;
    end while (!bus_a.o_frame && n < 100);
    chk("frame_seen", {31'b0, bus_a.o_frame}, 32'd1);
    pos = 0;
  endtask

  task automatic load(input logic [15:0] v, input logic [3:0] dp, input logic [3:0] bl);
    bus_a.i_load  = 1'b1;
    bus_a.i_val   = v;
    bus_a.i_dp    = dp;
    bus_a.i_blank = bl;
    step();
    bus_a.i_load  = 1'b0;
  endtask

  task automatic chk_a(input string tag, input logic [7:0] seg, input logic [3:0] sel);
    chk({tag, "_seg"}, {24'b0, bus_a.o_seg_vals}, {24'b0, seg});
    chk({tag, "_sel"}, {28'b0, bus_a.o_digit_sel}, {28'b0, sel});
  endtask

  task automatic chk_b(input string tag, input logic [7:0] seg, input logic [3:0] sel);
    chk({tag, "_bseg"}, {24'b0, bus_b.o_seg_vals}, {24'b0, seg});
    chk({tag, "_bsel"}, {28'b0, bus_b.o_digit_sel}, {28'b0, sel});
  endtask

  initial begin
    i_rst_n       = 1'b0;
    bus_a.i_en    = 1'b0;
    bus_a.i_load  = 1'b0;
    bus_a.i_val   = '0;
    bus_a.i_dp    = '0;
    bus_a.i_blank = '0;
    bus_a.i_lz_en = 1'b0;

    // Reset state
    @(negedge i_clk);
    chk_a("rst", 8'h00, 4'b0000);
    chk_b("rst", 8'hff, 4'b1111);
    chk("rst_pend", {31'b0, bus_a.o_pending}, 32'd0);
    chk("rst_frame", {31'b0, bus_a.o_frame}, 32'd0);

    // Release: digit 0 shows 0 from count DEAD_CYCLES+1
    i_rst_n    = 1'b1;
    bus_a.i_en = 1'b1;
    pos = 0;
    goto(2);  chk_a("boot_dead", 8'h00, 4'b0000);
    goto(3);  chk_a("boot_d0", 8'h5f, 4'b0001);
    chk_b("boot_d0", 8'ha0, 4'b1110);
    goto(12); chk_a("boot_d1", 8'h5f, 4'b0010);

    // 0x12AF committed at the frame boundary
    goto(13); load(16'h12af, 4'b0000, 4'b0000);
    chk("ld_pend", {31'b0, bus_a.o_pending}, 32'd1);
    wait_frame();
    chk("commit_pend", {31'b0, bus_a.o_pending}, 32'd0);
    goto(1);  chk("frame_pulse", {31'b0, bus_a.o_frame}, 32'd0);
    goto(4);  chk_a("v12af_d0", 8'h71, 4'b0001);
    chk_b("v12af_d0", 8'h8e, 4'b1110);
    goto(12); chk_a("v12af_d1", 8'h77, 4'b0010);
    goto(20); chk_a("v12af_d2", 8'h3b, 4'b0100);
    goto(28); chk_a("v12af_d3", 8'h06, 4'b1000);

    // Last write wins; old value held until commit
    wait_frame();
    goto(1);  load(16'h1111, 4'b0000, 4'b0000);
    goto(5);  load(16'h2222, 4'b0000, 4'b0000);
    chk("lww_pend", {31'b0, bus_a.o_pending}, 32'd1);
    goto(12); chk_a("lww_old_d1", 8'h77, 4'b0010);
    wait_frame();
    goto(4);  chk_a("lww_d0", 8'h3b, 4'b0001);
    goto(28); chk_a("lww_d3", 8'h3b, 4'b1000);

    // Decimal point on digit 2 only
    goto(29); load(16'h8888, 4'b0100, 4'b0000);
    wait_frame();
    goto(4);  chk_a("dp_d0", 8'h7f, 4'b0001);
    goto(20); chk_a("dp_d2", 8'hff, 4'b0100);
    goto(28); chk_a("dp_d3", 8'h7f, 4'b1000);

    // Leading-zero suppression
    bus_a.i_lz_en = 1'b1;
    goto(29); load(16'h0005, 4'b0000, 4'b0000);
    wait_frame();
    goto(4);  chk_a("lz5_d0", 8'h6d, 4'b0001);
    goto(12); chk_a("lz5_d1", 8'h00, 4'b0000);
    goto(28); chk_a("lz5_d3", 8'h00, 4'b0000);
    goto(29); load(16'h0000, 4'b0000, 4'b0000);
    wait_frame();
    goto(4);  chk_a("lz0_d0", 8'h5f, 4'b0001);
    goto(12); chk_a("lz0_d1", 8'h00, 4'b0000);

    // Load coinciding with the commit cycle goes straight to the display
    goto(31);
    load(16'h0001, 4'b0000, 4'b0000);
    pos = 0;
    chk("coinc_frame", {31'b0, bus_a.o_frame}, 32'd1);
    chk("coinc_pend", {31'b0, bus_a.o_pending}, 32'd0);
    goto(1);  chk_b("coinc_dead", 8'hff, 4'b1111);
    goto(4);  chk_a("coinc_d0", 8'h06, 4'b0001);
    chk_b("coinc_d0", 8'hf9, 4'b1110);
    goto(12); chk_b("coinc_d1", 8'hff, 4'b1111);

    // Forced blank suppresses the dp and the select
    bus_a.i_lz_en = 1'b0;
    goto(13); load(16'h0003, 4'b0001, 4'b0001);
    wait_frame();
    goto(4);  chk_a("blank_d0", 8'h00, 4'b0000);
    goto(12); chk_a("blank_d1", 8'h5f, 4'b0010);

    // Disable: outputs inactive, loads accepted, commit on re-enable
    goto(13);
    bus_a.i_en = 1'b0;
    step();
    chk_a("dis", 8'h00, 4'b0000);
    load(16'h0009, 4'b0000, 4'b0000);
    chk("dis_pend", {31'b0, bus_a.o_pending}, 32'd1);
    step(); step(); step();
    chk("dis_frame", {31'b0, bus_a.o_frame}, 32'd0);
    chk_b("dis", 8'hff, 4'b1111);
    bus_a.i_en = 1'b1;
    pos = 0;
    goto(1);  chk("reen_pend", {31'b0, bus_a.o_pending}, 32'd0);
    goto(3);  chk_a("reen_d0", 8'h6f, 4'b0001);

    // Asynchronous reset in the middle of digit 2's slot
    goto(20); chk_a("pre_rst_d2", 8'h5f, 4'b0100);
    #2 i_rst_n = 1'b0;
    #1;
    chk_a("async_rst", 8'h00, 4'b0000);
    chk_b("async_rst", 8'hff, 4'b1111);
    chk("async_rst_pend", {31'b0, bus_a.o_pending}, 32'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    pos = 0;
    goto(3);  chk_a("post_rst_d0", 8'h5f, 4'b0001);
    chk_b("post_rst_d0", 8'ha0, 4'b1110);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
